masked_relu_stream: RTL and testbench

MASKED_RELU_STREAM -- requirements
Module: masked_relu_stream

---
 rtl/masked_pkg.sv | 16 +
 rtl/masked_relu_lane.sv | 32 +++
 rtl/masked_relu_stream.sv | 131 +++++++++++++
 tb/tb_masked_relu_stream.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/masked_pkg.sv
// Shared definitions for the masked ReLU stream: default geometry, mode
// encodings and the lane-slice helper used to address packed lane buses.
package masked_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_LANES = 4;

    localparam logic MODE_RELU = 1'b0;
    localparam logic MODE_CLIP = 1'b1;

    // Lowest bit index of a lane inside a packed {lane N-1, ..., lane 0} bus.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/masked_relu_lane.sv
// One lane of the masked ReLU datapath. Purely combinational: the unmask
// path feeds stage 1, the compare/clip/remask path feeds stage 2.
module masked_relu_lane
    import masked_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] g_i,       // mask of the incoming beat
    input  logic [WIDTH-1:0] e_i,       // masked activation of the incoming beat
    output logic [WIDTH-1:0] u_o,       // unmasked value, registered by stage 1
    input  logic [WIDTH-1:0] s1_u_i,    // stage-1 unmasked value
    input  logic [WIDTH-1:0] s1_g_i,    // stage-1 mask
    input  logic             s1_mode_i, // stage-1 captured mode
    input  logic [WIDTH-1:0] s1_clip_i, // stage-1 captured clip ceiling
    output logic [WIDTH-1:0] o_o,       // remasked result for stage 2
    output logic             neg_o      // stage-1 value is negative
);

    // Unmask, then rectify/clip in the signed domain and remask with g.
    always_comb begin
        u_o   = g_i + e_i;
        neg_o = s1_u_i[WIDTH-1];
        if (s1_u_i[WIDTH-1]) begin
            o_o = s1_g_i;
        end else if (s1_mode_i == MODE_CLIP && $signed(s1_u_i) > $signed(s1_clip_i)) begin
            o_o = s1_clip_i + s1_g_i;
        end else begin
            o_o = s1_u_i + s1_g_i;
        end
    end

endmodule

// File: rtl/masked_relu_stream.sv
// Two-stage masked ReLU / clipped ReLU stream with valid/ready handshakes.
// Handshake: a beat moves across an interface in a cycle where valid and
// ready are both high at the rising edge; valid never depends on ready, and
// a stage advances only when the stage after it is empty or draining.
module masked_relu_stream
    import masked_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] g_input,
    input  logic [LANES*WIDTH-1:0] e_input,
    input  logic                   cfg_mode,
    input  logic [WIDTH-1:0]       cfg_clip,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] o,
    output logic [CNT_W-1:0]       neg_count
);

    localparam int NSW = $clog2(LANES + 1);
    localparam int SW  = CNT_W + NSW;

    logic                         s1_valid_q, s1_valid_d;
    logic [LANES-1:0][WIDTH-1:0]  s1_u_q, s1_u_d;
    logic [LANES-1:0][WIDTH-1:0]  s1_g_q, s1_g_d;
    logic                         s1_mode_q, s1_mode_d;
    logic [WIDTH-1:0]             s1_clip_q, s1_clip_d;
    logic                         s2_valid_q, s2_valid_d;
    logic [LANES*WIDTH-1:0]       o_q, o_d;
    logic [CNT_W-1:0]             neg_count_q, neg_count_d;

    logic [LANES-1:0][WIDTH-1:0]  lane_u;
    logic [LANES-1:0][WIDTH-1:0]  lane_o;
    logic [LANES-1:0]             lane_neg;
    logic [NSW-1:0]               neg_sum;
    logic [SW-1:0]                cnt_sum;
    logic                         adv1, adv2;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        masked_relu_lane #(.WIDTH(WIDTH)) u_lane (
            .g_i       (g_input[lane_lsb(i, WIDTH) +: WIDTH]),
            .e_i       (e_input[lane_lsb(i, WIDTH) +: WIDTH]),
            .u_o       (lane_u[i]),
            .s1_u_i    (s1_u_q[i]),
            .s1_g_i    (s1_g_q[i]),
            .s1_mode_i (s1_mode_q),
            .s1_clip_i (s1_clip_q),
            .o_o       (lane_o[i]),
            .neg_o     (lane_neg[i])
        );
    end

    // Stage enables: stage 2 drains or is empty, stage 1 likewise feeds it.
    assign adv2      = !s2_valid_q || out_ready;
    assign adv1      = !s1_valid_q || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid_q;
    assign o         = o_q;
    assign neg_count = neg_count_q;

    // Number of negative lanes in stage 1, and the saturating counter sum.
    always_comb begin
        neg_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            neg_sum = neg_sum + NSW'(lane_neg[i]);
        end
        cnt_sum = SW'(neg_count_q) + SW'(neg_sum);
    end

    // Next-state for both pipeline stages and the status counter.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_u_d      = s1_u_q;
        s1_g_d      = s1_g_q;
        s1_mode_d   = s1_mode_q;
        s1_clip_d   = s1_clip_q;
        s2_valid_d  = s2_valid_q;
        o_d         = o_q;
        neg_count_d = neg_count_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_u_d    = lane_u;
                s1_g_d    = g_input;
                s1_mode_d = cfg_mode;
                s1_clip_d = cfg_clip;
            end
        end
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                o_d = lane_o;
                if (cnt_sum > {{NSW{1'b0}}, {CNT_W{1'b1}}}) begin
                    neg_count_d = '1;
                end else begin
                    neg_count_d = cnt_sum[CNT_W-1:0];
                end
            end
        end
    end

    // Pipeline and counter registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_u_q      <= '0;
            s1_g_q      <= '0;
            s1_mode_q   <= 1'b0;
            s1_clip_q   <= '0;
            s2_valid_q  <= 1'b0;
            o_q         <= '0;
            neg_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_u_q      <= s1_u_d;
            s1_g_q      <= s1_g_d;
            s1_mode_q   <= s1_mode_d;
            s1_clip_q   <= s1_clip_d;
            s2_valid_q  <= s2_valid_d;
            o_q         <= o_d;
            neg_count_q <= neg_count_d;
        end
    end

endmodule

// File: tb/tb_masked_relu_stream.sv
// Bench for masked_relu_stream at WIDTH=8, LANES=4, CNT_W=4: a directed
// vector table, reset/latency sequences, and randomized traffic checked
// against an arithmetic reference model with an expected-beat queue.
module tb_masked_relu_stream;
    import masked_pkg::*;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int C  = 4;
    localparam int BW = W * L;
    localparam int CNT_MAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] g_input = '0;
    logic [BW-1:0] e_input = '0;
    logic          cfg_mode = 1'b0;
    logic [W-1:0]  cfg_clip = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BW-1:0] o;
    logic [C-1:0]  neg_count;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    masked_relu_stream #(.WIDTH(W), .LANES(L), .CNT_W(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g_input   (g_input),
        .e_input   (e_input),
        .cfg_mode  (cfg_mode),
        .cfg_clip  (cfg_clip),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .neg_count (neg_count)
    );

    // ---------------- scoreboard state ----------------
    int            n_cmp = 0;
    int            n_fail = 0;
    logic [BW-1:0] exp_q[$];
    int            exp_neg = 0;
    int            rdy_mode = 0;
    int            cyc = 0;

    typedef struct {
        logic [W-1:0] g;
        logic [W-1:0] e;
        logic         mode;
        logic [W-1:0] clip;
        logic [W-1:0] exp_o;
        int           neg_inc;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: unmask, interpret as signed, rectify/clip, remask.
    function automatic logic [W-1:0] ref_lane(input logic [W-1:0] g, input logic [W-1:0] e,
                                              input logic mode, input logic [W-1:0] clip);
        int gi, u, su, ci;
        gi = int'(g);
        ci = int'(clip);
        u  = (gi + int'(e)) % 256;
        su = (u >= 128) ? u - 256 : u;
        if (su < 0) return g;
        if (mode && su > ci) return W'((ci + gi) % 256);
        return W'((u + gi) % 256);
    endfunction

    function automatic int ref_negs(input logic [BW-1:0] g, input logic [BW-1:0] e);
        int n = 0;
        for (int i = 0; i < L; i++) begin
            if ((int'(g[i*W +: W]) + int'(e[i*W +: W])) % 256 >= 128) n++;
        end
        return n;
    endfunction

    // ---------------- out_ready pattern ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (rdy_mode)
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got o=%h with no beat expected (t=%0t)", o, $time);
                end else begin
                    check("stream_o", o, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [BW-1:0] g, input logic [BW-1:0] e, input logic mode,
                        input logic [W-1:0] clip, output int stalls);
        logic          acc;
        logic [BW-1:0] eb;
        int            n;
        g_input  = g;
        e_input  = e;
        cfg_mode = mode;
        cfg_clip = clip;
        in_valid = 1'b1;
        stalls   = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            stalls++;
            if (stalls > 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout: got no in_ready in %0d cycles expected acceptance", stalls);
                break;
            end
        end
        in_valid = 1'b0;
        if (acc) begin
            for (int i = 0; i < L; i++) begin
                eb[i*W +: W] = ref_lane(g[i*W +: W], e[i*W +: W], mode, clip);
            end
            exp_q.push_back(eb);
            n = exp_neg + ref_negs(g, e);
            exp_neg = (n > CNT_MAX) ? CNT_MAX : n;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 500) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        check("drain_out_valid", BW'(out_valid), BW'(0));
        check("drain_neg_count", BW'(neg_count), BW'(exp_neg));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_neg = 0;
        @(negedge clk);
        check("rst_out_valid", BW'(out_valid), BW'(0));
        check("rst_neg_count", BW'(neg_count), BW'(0));
        check("rst_o", o, BW'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", BW'(in_ready), BW'(1));
        @(posedge clk);
        #1;
    endtask

    // Send one beat with out_ready high and check the exact 2-cycle latency.
    task automatic send_lat(input logic [BW-1:0] g, input logic [BW-1:0] e, input logic mode,
                            input logic [W-1:0] clip, input logic [BW-1:0] exp_o, input int exp_cnt);
        int st;
        send(g, e, mode, clip, st);
        check("lat_stalls", BW'(st), BW'(0));
        @(negedge clk);
        check("lat_cycle1_valid", BW'(out_valid), BW'(0));
        @(negedge clk);
        check("lat_cycle2_valid", BW'(out_valid), BW'(1));
        check("lat_o", o, exp_o);
        check("lat_neg_count", BW'(neg_count), BW'(exp_cnt));
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int            st;
        int            cnt;
        logic [BW-1:0] rg, re;

        tbl[0]  = '{8'h10, 8'hF5, MODE_RELU, 8'h06, 8'h15, 0};
        tbl[1]  = '{8'h10, 8'hE0, MODE_RELU, 8'h06, 8'h10, 1};
        tbl[2]  = '{8'h10, 8'h30, MODE_CLIP, 8'h06, 8'h16, 0};
        tbl[3]  = '{8'h10, 8'h16, MODE_CLIP, 8'h06, 8'h16, 0};
        tbl[4]  = '{8'h20, 8'hE6, MODE_CLIP, 8'h06, 8'h26, 0};
        tbl[5]  = '{8'h20, 8'hE7, MODE_CLIP, 8'h06, 8'h26, 0};
        tbl[6]  = '{8'h10, 8'hF0, MODE_RELU, 8'h06, 8'h10, 0};
        tbl[7]  = '{8'h01, 8'h7E, MODE_RELU, 8'h06, 8'h80, 0};
        tbl[8]  = '{8'h01, 8'h7F, MODE_RELU, 8'h06, 8'h01, 1};
        tbl[9]  = '{8'h00, 8'h7F, MODE_CLIP, 8'h06, 8'h06, 0};
        tbl[10] = '{8'h10, 8'hF5, MODE_CLIP, 8'h06, 8'h15, 0};
        tbl[11] = '{8'h05, 8'hFB, MODE_CLIP, 8'h00, 8'h05, 0};
        tbl[12] = '{8'h05, 8'hFC, MODE_CLIP, 8'h00, 8'h05, 0};

        do_reset();

        // Directed vectors in lane 0; other lanes carry zero.
        rdy_mode = 0;
        cnt = 0;
        for (int i = 0; i < 13; i++) begin
            cnt += tbl[i].neg_inc;
            send_lat({24'h0, tbl[i].g}, {24'h0, tbl[i].e}, tbl[i].mode, tbl[i].clip,
                     {24'h0, tbl[i].exp_o}, cnt);
        end
        drain();

        // Reset with two negative beats in flight, then latency from clean state.
        send({4{8'h00}}, {4{8'h80}}, MODE_RELU, 8'h00, st);
        send({4{8'h00}}, {4{8'h90}}, MODE_RELU, 8'h00, st);
        do_reset();
        send_lat({4{8'h10}}, {4{8'hF5}}, MODE_RELU, 8'h00, {4{8'h15}}, 0);
        drain();

        // Burst of 8 under the 1,0,0,1 out_ready pattern.
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            rg = BW'($urandom);
            re = BW'($urandom);
            send(rg, re, 1'($urandom_range(0, 1)), W'($urandom_range(0, 127)), st);
        end
        drain();

        // Full-rate stream: every beat accepted without a stall.
        rdy_mode = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            rg = BW'($urandom);
            re = BW'($urandom);
            send(rg, re, 1'($urandom_range(0, 1)), W'($urandom_range(0, 127)), st);
            check("full_rate_stalls", BW'(st), BW'(0));
        end
        drain();

        // Random traffic with random gaps, backpressure and per-beat config.
        rdy_mode = 2;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            rg = BW'($urandom);
            re = BW'($urandom);
            send(rg, re, 1'($urandom_range(0, 1)), W'($urandom_range(0, 127)), st);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        drain();

        // Counter saturation: 20 negative lanes into a 4-bit counter.
        do_reset();
        for (int i = 0; i < 3; i++) send({4{8'h01}}, {4{8'hA0}}, MODE_RELU, 8'h00, st);
        drain();
        check("sat_partial", BW'(neg_count), BW'(12));
        for (int i = 0; i < 2; i++) send({4{8'h01}}, {4{8'hA0}}, MODE_RELU, 8'h00, st);
        drain();
        check("sat_full", BW'(neg_count), BW'(15));
        send({4{8'h01}}, {4{8'hA0}}, MODE_CLIP, 8'h10, st);
        drain();
        check("sat_hold", BW'(neg_count), BW'(15));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
